// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store unit bridging a core request port to a word-indexed data memory
module mem_access_unit #(
    parameter int DEPTH_WORDS = 32,
    parameter int TIMEOUT     = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_readsig,
    output logic        mem_writesig,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] load_count,
    output logic [15:0] store_count
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [60:0]         word_q, word_d;
    logic [63:0]         wdata_q, wdata_d;
    logic [63:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [15:0]         load_count_q, load_count_d;
    logic [15:0]         store_count_q, store_count_d;

    logic req_bad;
    logic timed_out;
    logic in_issue;

    assign req_bad   = (req_addr[2:0] != 3'b000) || ((req_addr >> 3) >= 64'(DEPTH_WORDS));
    // Wait counter reaching TIMEOUT coincides with this edge, so compare against TIMEOUT-1.
    assign timed_out = (wait_q == WAIT_W'(TIMEOUT - 1));
    assign in_issue  = (state_q == ISSUE);

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        word_d        = word_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        wait_d        = wait_q;
        load_count_d  = load_count_q;
        store_count_d = store_count_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    word_d  = req_addr[63:3];
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    wait_d  = '0;
                    err_d   = req_bad;
                    state_d = req_bad ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                // mem_ack takes priority over a timeout landing on the same edge.
                if (mem_ack) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = write_q ? 64'd0 : mem_rdata;
                end else if (timed_out) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    if (!err_q && write_q && store_count_q != 16'hFFFF) begin
                        store_count_d = store_count_q + 16'd1;
                    end
                    if (!err_q && !write_q && load_count_q != 16'hFFFF) begin
                        load_count_d = load_count_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            write_q       <= 1'b0;
            word_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            wait_q        <= '0;
            load_count_q  <= '0;
            store_count_q <= '0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            word_q        <= word_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
            wait_q        <= wait_d;
            load_count_q  <= load_count_d;
            store_count_q <= store_count_d;
        end
    end

    // Outputs decode straight from state so an asynchronous reset drops them immediately.
    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_rdata   = resp_valid ? rdata_q : 64'd0;
    assign resp_err     = resp_valid & err_q;
    assign mem_addr     = in_issue ? {3'b000, word_q} : 64'd0;
    assign mem_wdata    = in_issue ? wdata_q : 64'd0;
    assign mem_readsig  = in_issue & ~write_q;
    assign mem_writesig = in_issue & write_q;
    assign load_count   = load_count_q;
    assign store_count  = store_count_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - table-driven and randomized checks of mem_access_unit against a transaction-level model
module tb_mem_access_unit;
    localparam int DEPTH   = 32;
    localparam int TMO     = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_readsig, mem_writesig, mem_ack;
    logic [15:0] load_count, store_count;

    mem_access_unit #(.DEPTH_WORDS(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_readsig(mem_readsig), .mem_writesig(mem_writesig),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .load_count(load_count), .store_count(store_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] sim_mem [DEPTH];
    logic [63:0] ref_mem [DEPTH];
    int          ref_loads  = 0;
    int          ref_stores = 0;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          ack_at;
        int          hold;
        logic        exp_err;
        int          exp_strobes;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    // Outcome of one access from the rules alone: address check, then ack position vs. timeout budget.
    task automatic model(input logic [63:0] addr, input int ack_at, output logic err, output int strobes);
        if (addr[2:0] != 3'b000 || (addr / 8) >= 64'(DEPTH)) begin
            err = 1'b1; strobes = 0;
        end else if (ack_at >= 1 && ack_at <= TMO) begin
            err = 1'b0; strobes = ack_at;
        end else begin
            err = 1'b1; strobes = TMO;
        end
    endtask

    // Entered and left at a negedge with the unit idle.
    task automatic do_access(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                             input int ack_at, input int hold, input logic exp_err, input int exp_strobes);
        int          n;
        int          cyc;
        logic        done;
        logic [63:0] exp_rdata;
        logic [4:0]  w;
        w = addr[7:3];
        exp_rdata = (!exp_err && !wr) ? ref_mem[w] : 64'd0;
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        n = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) begin
                done = 1'b1;
            end else begin
                if (mem_readsig || mem_writesig) begin
                    n++;
                    chk("mem_writesig", 64'(mem_writesig), 64'(wr));
                    chk("mem_readsig", 64'(mem_readsig), 64'(!wr));
                    chk("mem_addr", mem_addr, addr / 8);
                    chk("mem_wdata", mem_wdata, wdata);
                    if (n == ack_at) begin
                        mem_ack   = 1'b1;
                        mem_rdata = sim_mem[mem_addr[4:0]];
                        if (mem_writesig) sim_mem[mem_addr[4:0]] = mem_wdata;
                    end else begin
                        mem_ack   = 1'b0;
                        mem_rdata = {$urandom, $urandom};
                    end
                end
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
        end
        chk("resp_within_bound", 64'(done), 64'd1);
        chk("strobe_cycles", 64'(n), 64'(exp_strobes));
        chk("resp_latency", 64'(cyc), 64'(exp_strobes + 1));
        if (!exp_err && wr) ref_mem[w] = wdata;
        for (int h = 0; h <= hold; h++) begin
            mem_ack   = 1'($urandom);
            mem_rdata = {$urandom, $urandom};
            chk("resp_valid", 64'(resp_valid), 64'd1);
            chk("resp_err", 64'(resp_err), 64'(exp_err));
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("req_ready_in_resp", 64'(req_ready), 64'd0);
            chk("strobes_in_resp", 64'({mem_readsig, mem_writesig}), 64'd0);
            resp_ready = (h == hold);
            @(posedge clk); #1;
            resp_ready = 1'b0;
            mem_ack    = 1'b0;
            @(negedge clk);
        end
        if (!exp_err && wr)  ref_stores++;
        if (!exp_err && !wr) ref_loads++;
        chk("req_ready_after", 64'(req_ready), 64'd1);
        chk("resp_valid_after", 64'(resp_valid), 64'd0);
        chk("load_count", 64'(load_count), 64'(sat16(ref_loads)));
        chk("store_count", 64'(store_count), 64'(sat16(ref_stores)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        int          s;
        logic [63:0] a;
        logic [63:0] d;
        int          ack;

        for (int i = 0; i < DEPTH; i++) begin
            sim_mem[i] = {$urandom, $urandom};
            ref_mem[i] = sim_mem[i];
        end
        sim_mem[10] = 64'd1540;
        ref_mem[10] = 64'd1540;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_strobes", 64'({mem_readsig, mem_writesig}), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_counts", 64'({load_count, store_count}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0]  = '{1'b0, 64'h50,  64'h0,      1,  0, 1'b0, 1};
        vecs[1]  = '{1'b1, 64'h58,  64'hABCD,   3,  0, 1'b0, 3};
        vecs[2]  = '{1'b0, 64'h58,  64'h1234,   2,  1, 1'b0, 2};
        vecs[3]  = '{1'b0, 64'h0C,  64'h0,      1,  0, 1'b1, 0};
        vecs[4]  = '{1'b0, 64'h100, 64'h0,      1,  0, 1'b1, 0};
        vecs[5]  = '{1'b0, 64'h50,  64'h0,      0,  0, 1'b1, 15};
        vecs[6]  = '{1'b0, 64'h50,  64'h0,      15, 0, 1'b0, 15};
        vecs[7]  = '{1'b1, 64'h50,  64'h77,     16, 0, 1'b1, 15};
        vecs[8]  = '{1'b1, 64'hF8,  64'hBEEF,   1,  5, 1'b0, 1};
        vecs[9]  = '{1'b1, 64'h100, 64'h99,     1,  5, 1'b1, 0};
        vecs[10] = '{1'b0, 64'hF8,  64'h0,      2,  0, 1'b0, 2};
        for (int i = 0; i < 11; i++) begin
            do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack_at,
                      vecs[i].hold, vecs[i].exp_err, vecs[i].exp_strobes);
        end

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1: a = 64'($urandom_range(0, DEPTH - 1)) * 8;
                2:    a = 64'($urandom_range(0, DEPTH - 1)) * 8 + 64'($urandom_range(1, 7));
                default: a = 64'(DEPTH) * 8 + 64'($urandom_range(0, 4)) * 8 * 64'($urandom_range(1, 1000));
            endcase
            d   = {$urandom, $urandom};
            ack = $urandom_range(0, TMO + 2);
            model(a, ack, e, s);
            do_access(1'($urandom), a, d, ack, $urandom_range(0, 3), e, s);
        end

        // Reset in the middle of an ISSUE wait.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h50; req_wdata = '0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_readsig", 64'(mem_readsig), 64'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_strobes", 64'({mem_readsig, mem_writesig}), 64'd0);
        chk("async_rst_mem_addr", mem_addr, 64'd0);
        chk("async_rst_req_ready", 64'(req_ready), 64'd1);
        chk("async_rst_counts", 64'({load_count, store_count}), 64'd0);
        ref_loads = 0; ref_stores = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1;
            @(negedge clk);
            chk("post_rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("post_rst_idle", 64'({req_ready, mem_readsig, mem_writesig}), 64'b100);
        end
        mem_ack = 1'b0;
        do_access(1'b0, 64'h50, 64'h0, 1, 0, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DEPTH_WORDS  32  number of 64-bit words behind the memory port
  TIMEOUT      15  ISSUE-state cycles allowed without mem_ack before an error response
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk           in   1   single clock; all state changes on its rising edge
  rst_n         in   1   asynchronous, active-low reset
  req_valid     in   1   core presents an access
  req_ready     out  1   unit accepts an access
  req_write     in   1   1 = store (STUR), 0 = load (LDUR)
  req_addr      in   64  byte address
  req_wdata     in   64  store data
  resp_valid    out  1   response available
  resp_ready    in   1   core consumes the response
  resp_rdata    out  64  load data (0 for stores and errors)
  resp_err      out  1   misaligned, out-of-range or timed out
  mem_addr      out  64  word index to data memory
  mem_wdata     out  64  write data to data memory
  mem_readsig   out  1   read strobe
  mem_writesig  out  1   write strobe
  mem_rdata     in   64  read data from data memory
  mem_ack       in   1   memory completed the strobed access
  load_count    out  16  accepted loads that completed without error, saturating
  store_count   out  16  accepted stores that completed without error, saturating

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ISSUE, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a handshake is req_valid && req_ready on a rising clk edge.
REQ-005 On handshake the unit SHALL latch req_write, req_addr and req_wdata; later req_* changes SHALL have no effect until the next handshake.
REQ-006 Error check at handshake: misaligned if req_addr[2:0] != 0; out-of-range if (req_addr >> 3) >= DEPTH_WORDS.
REQ-007 A handshake that fails the REQ-006 check SHALL go IDLE -> RESP with resp_err = 1 and resp_rdata = 0; no memory strobe SHALL be asserted.
REQ-008 A handshake that passes the REQ-006 check SHALL go IDLE -> ISSUE.
REQ-009 In ISSUE, mem_addr SHALL equal latched addr >> 3 and mem_wdata SHALL equal the latched wdata.
REQ-010 In ISSUE, mem_readsig SHALL be !write and mem_writesig SHALL be write; both strobes SHALL be 0 in every other state and never 1 together.
REQ-011 mem_addr and mem_wdata SHALL be 0 outside ISSUE.
REQ-012 On mem_ack = 1 in ISSUE the unit SHALL move to RESP with resp_err = 0; for a load it SHALL capture mem_rdata into resp_rdata on that edge; for a store resp_rdata SHALL be 0.
REQ-013 A wait counter SHALL clear on entry to ISSUE and increment each ISSUE cycle without mem_ack.
REQ-014 When the wait counter reaches TIMEOUT, the unit SHALL move to RESP with resp_err = 1 and resp_rdata = 0, and the strobes SHALL drop on that edge.
REQ-015 If mem_ack and timeout occur on the same edge, mem_ack SHALL win (success).
REQ-016 Minimum latency from handshake edge N: strobes during cycle N+1; with mem_ack in that cycle, resp_valid = 1 from edge N+2.
REQ-017 Minimum latency for an error: resp_valid = 1 from edge N+1.
REQ-018 resp_valid SHALL be 1 only in RESP; resp_rdata and resp_err SHALL be stable while resp_valid && !resp_ready.
REQ-019 RESP -> IDLE SHALL occur on resp_valid && resp_ready; the next handshake is possible one cycle later (no same-cycle accept).
REQ-020 mem_ack outside ISSUE SHALL be ignored.
REQ-021 load_count / store_count SHALL increment by 1 on the RESP -> IDLE edge of an error-free load / store respectively, and SHALL hold at 16'hFFFF.

Reset
REQ-022 rst_n = 0 SHALL immediately, without waiting for clk, force state IDLE, clear the wait counter, the latched request, both counters and all outputs, with req_ready = 1 while rst_n is low.
REQ-023 Reset during ISSUE or RESP SHALL abandon the access: strobes drop asynchronously and no response is issued after release.

Verification
REQ-024 Bench SHALL cover: load, addr = 0x50, mem_ack in the first ISSUE cycle, mem_rdata = 1540 -> mem_addr = 10 with mem_readsig = 1 at N+1; resp_valid, resp_rdata = 1540, resp_err = 0 at N+2; load_count = 1 after the response handshake.
REQ-025 Bench SHALL cover: store, addr = 0x58, wdata = 0xABCD, mem_ack after 3 cycles -> mem_writesig = 1 for exactly 3 cycles with mem_addr = 11 and mem_wdata = 0xABCD; then resp_err = 0, resp_rdata = 0, store_count = 1.
REQ-026 Bench SHALL cover: load at addr = 0x0C, then at addr = 0x100 (DEPTH_WORDS = 32) -> resp_valid at N+1 with resp_err = 1; strobes never asserted; counters unchanged.
REQ-027 Bench SHALL cover: load with mem_ack never asserted -> mem_readsig high for exactly 15 cycles, then resp_err = 1; a separate run with mem_ack on the 15th cycle -> success.
REQ-028 Bench SHALL cover: resp_ready held 0 for 5 cycles, then 1 -> resp fields stable throughout and req_ready = 1 only on the following cycle; rst_n pulsed low mid-ISSUE -> strobes 0 before the next clk edge and state IDLE after release.
